// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and parity mode constants.
// Used by the transmitter and by the bit timer's future receiver sibling.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: counts CLK_DIV cycles per serial bit.
// Ports:
//   clk, res   - clock, async active-high reset
//   restart    - reload the counter so a full bit period starts next cycle
//   bit_done   - high in the last cycle of each bit period
module uart_bit_timer #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic res,
    input  logic restart,
    output logic bit_done
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q;

    // Reload on restart or when a bit period ends; otherwise count down.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == '0)) begin
            cnt_q <= CNT_W'(CLK_DIV - 1);
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign bit_done = (cnt_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a FIFO: pops one word per frame and sends
// start bit, WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Ports:
//   clk, res        - clock, async active-high reset
//   enable          - permits starting a new frame (checked at frame boundaries)
//   fifo_empty      - FIFO empty flag
//   fifo_rdata      - FIFO head word
//   fifo_shift_out  - one-cycle pop strobe (decoded from state, enable, empty)
//   tx              - registered serial line, idle high
//   busy            - high from the pop cycle through the last stop-bit cycle
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_shift_out,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned IDX_W = $clog2(WIDTH + 1);

    uart_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shifted;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             armed_q;
    logic             can_pop;
    logic             load;
    logic             pop_c;
    logic             bit_done;

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .res      (res),
        .restart  (pop_c),
        .bit_done (bit_done)
    );

    // Blocks any pop during reset and in the first cycle after release.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    assign can_pop = enable & ~fifo_empty & armed_q;
    assign shifted = shift_q >> 1;

    // State and datapath registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state, next tx value and pop decode.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;
        pop_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                load = can_pop;
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d = shifted;
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shifted[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    idx_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        if (can_pop) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Pop and latch the head word; start bit goes out next cycle.
        if (load) begin
            pop_c   = 1'b1;
            shift_d = fifo_rdata;
            par_d   = (PARITY == PAR_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);
            idx_d   = '0;
            state_d = S_START;
            tx_d    = 1'b0;
        end
    end

    assign tx             = tx_q;
    assign fifo_shift_out = pop_c;
    assign busy           = pop_c | (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four instances (no/even/odd parity, two stop bits)
// fed the same word stream, each checked cycle by cycle against a frame-position
// model of the expected line waveform, busy and pop strobe.
module tb_fifo_uart_tx;

    localparam int N    = 4;
    localparam int CDIV = 4;
    localparam int W    = 8;

    logic       clk;
    logic       res;
    logic       enable;
    logic       empty [N];
    logic [7:0] rdata [N];
    logic       pop   [N];
    logic       tx    [N];
    logic       busy  [N];

    logic [7:0] words [$];
    int         rd [N];
    int         pos [N];
    logic [7:0] word [N];
    logic       exp_pop_s [N];
    logic       dut_pop_s [N];
    logic [7:0] rdata_s [N];
    logic       armed_m;

    int checks;
    int errors;

    function automatic int par_of(int i);
        return (i == 1) ? 1 : (i == 2) ? 2 : 0;
    endfunction

    function automatic int sb_of(int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(int i);
        return CDIV * (1 + W + ((par_of(i) != 0) ? 1 : 0) + sb_of(i));
    endfunction

    // Line level at cycle p of a frame carrying w.
    function automatic logic exp_bit(int i, logic [7:0] w, int p);
        int k;
        k = p / CDIV;
        if (k == 0) return 1'b0;
        if (k <= W) return w[k-1];
        if (par_of(i) != 0 && k == W + 1) return (par_of(i) == 1) ? (^w) : ~(^w);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        fifo_uart_tx #(
            .WIDTH     (W),
            .CLK_DIV   (CDIV),
            .PARITY    ((g == 1) ? 1 : (g == 2) ? 2 : 0),
            .STOP_BITS ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk            (clk),
            .res            (res),
            .enable         (enable),
            .fifo_empty     (empty[g]),
            .fifo_rdata     (rdata[g]),
            .fifo_shift_out (pop[g]),
            .tx             (tx[g]),
            .busy           (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh_fifo();
        for (int i = 0; i < N; i++) begin
            empty[i] = (rd[i] >= words.size());
            rdata[i] = empty[i] ? 8'h00 : words[rd[i]];
        end
    endtask

    task automatic push(input logic [7:0] w);
        words.push_back(w);
        refresh_fifo();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Per-cycle comparison against the frame model.
    always @(negedge clk) begin
        if (res) begin
            armed_m = 1'b0;
            for (int i = 0; i < N; i++) pos[i] = -1;
        end
        for (int i = 0; i < N; i++) begin
            logic ep, et, eb;
            ep = armed_m && enable && !empty[i] &&
                 (pos[i] < 0 || pos[i] == frame_len(i) - 1);
            et = (pos[i] < 0) ? 1'b1 : exp_bit(i, word[i], pos[i]);
            eb = (pos[i] >= 0) || ep;
            check($sformatf("tx[%0d]", i), int'(tx[i]), int'(et));
            check($sformatf("busy[%0d]", i), int'(busy[i]), int'(eb));
            check($sformatf("pop[%0d]", i), int'(pop[i]), int'(ep));
            check($sformatf("pop_when_empty[%0d]", i), int'(pop[i] & empty[i]), 0);
            exp_pop_s[i] = ep;
            dut_pop_s[i] = pop[i];
            rdata_s[i]   = rdata[i];
        end
    end

    // Advance the model and the FIFO read pointers after each edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (res) begin
                pos[i] = -1;
            end else begin
                if (exp_pop_s[i]) begin
                    pos[i]  = 0;
                    word[i] = rdata_s[i];
                end else if (pos[i] >= 0) begin
                    pos[i] = pos[i] + 1;
                    if (pos[i] >= frame_len(i)) pos[i] = -1;
                end
                if (dut_pop_s[i]) rd[i] = rd[i] + 1;
            end
            exp_pop_s[i] = 1'b0;
            dut_pop_s[i] = 1'b0;
        end
        armed_m = !res;
        refresh_fifo();
    end

    task automatic check_drained(input string tag, input int left);
        for (int i = 0; i < N; i++)
            check($sformatf("%s[%0d]", tag, i), words.size() - rd[i], left);
    endtask

    initial begin
        int budget;
        logic done;
        checks  = 0;
        errors  = 0;
        res     = 1'b1;
        enable  = 1'b0;
        armed_m = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd[i] = 0; pos[i] = -1; word[i] = 8'h00;
            exp_pop_s[i] = 1'b0; dut_pop_s[i] = 1'b0; rdata_s[i] = 8'h00;
        end
        refresh_fifo();

        tick(3);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_tx[%0d]", i), int'(tx[i]), 1);
            check($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
            check($sformatf("rst_pop[%0d]", i), int'(pop[i]), 0);
        end
        res = 1'b0;
        tick(2);

        // Single word 0xA5.
        push(8'hA5);
        enable = 1'b1;
        tick(60);
        check_drained("single", 0);

        // Three words back to back.
        push(8'h01); push(8'h02); push(8'h03);
        tick(3 * 48 + 20);
        check_drained("b2b", 0);

        // Enable dropped mid-DATA of the first of two queued words.
        push(8'($urandom)); push(8'($urandom));
        tick(20);
        enable = 1'b0;
        tick(60);
        check_drained("hold", 1);
        enable = 1'b1;
        tick(60);
        check_drained("resume", 0);

        // Reset mid-DATA.
        push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
        tick(25);
        res = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("midrst_tx[%0d]", i), int'(tx[i]), 1);
            check($sformatf("midrst_busy[%0d]", i), int'(busy[i]), 0);
            check($sformatf("midrst_pop[%0d]", i), int'(pop[i]), 0);
        end
        tick(3);
        res = 1'b0;
        tick(200);
        check_drained("post_rst", 0);

        // Randomized traffic with enable toggling and occasional resets.
        repeat (40) begin
            if ($urandom_range(0, 2) != 0) push(8'($urandom));
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                res = 1'b1;
                tick(2);
                res = 1'b0;
            end
            tick($urandom_range(1, 40));
        end

        // Drain with a bounded wait.
        enable = 1'b1;
        budget = 48 * (words.size() + 2) + 200;
        done   = 1'b0;
        while (!done && budget > 0) begin
            tick(1);
            budget = budget - 1;
            done = 1'b1;
            for (int i = 0; i < N; i++)
                if (rd[i] < words.size() || busy[i]) done = 1'b0;
        end
        check("drain_done", int'(done), 1);
        check_drained("final", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
